// File: rtl/torus_fifo_router_pkg.sv
// Shared definitions for the torus router: port numbering, direction
// encodings, flit width and the round-robin index helper.
package torus_fifo_router_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_PE = 3'd0,
    PORT_N  = 3'd1,
    PORT_S  = 3'd2,
    PORT_E  = 3'd3,
    PORT_W  = 3'd4
  } port_e;

  function automatic int flit_width(input int data_width, input int addr_width);
    return data_width + 2 * addr_width;
  endfunction

  // (base + off) mod 5, both operands in 0..4
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

endpackage

// File: rtl/torus_fifo_router_if.sv
// Flit handshake bundle for all five router ports; port p occupies bit p
// of the vectors and slice [p*FLIT_W +: FLIT_W] of the data buses.
interface torus_fifo_router_if
  import torus_fifo_router_pkg::*;
#(
  parameter int FLIT_W = 20
);
  logic [NUM_PORTS-1:0]        i_valid;
  logic [NUM_PORTS*FLIT_W-1:0] i_data;
  logic [NUM_PORTS-1:0]        i_ready;
  logic [NUM_PORTS-1:0]        o_valid;
  logic [NUM_PORTS*FLIT_W-1:0] o_data;
  logic [NUM_PORTS-1:0]        o_ready;

  modport master (output i_valid, i_data, o_ready, input i_ready, o_valid, o_data);
  modport slave  (input i_valid, i_data, o_ready, output i_ready, o_valid, o_data);
endinterface

// File: rtl/torus_fifo_router_in_fifo.sv
// First-word-fall-through input buffer: a pushed word becomes visible at
// head on the cycle after the push edge.
module router_in_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/torus_fifo_router.sv
// Five-port torus router: per-input FWFT FIFOs, dimension-order X-then-Y
// routing with shortest wrap direction, round-robin arbitration per output.
module torus_fifo_router
  import torus_fifo_router_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int MESH_SIZE  = 4,
  parameter int X_cord     = 0,
  parameter int Y_cord     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  torus_fifo_router_if.slave  bus
);
  localparam int FLIT_W = flit_width(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] MESH_L = (ADDR_WIDTH+1)'(MESH_SIZE);
  localparam logic [ADDR_WIDTH:0] X_L    = (ADDR_WIDTH+1)'(X_cord);
  localparam logic [ADDR_WIDTH:0] Y_L    = (ADDR_WIDTH+1)'(Y_cord);

  logic [FLIT_W-1:0]    head      [NUM_PORTS];
  logic [2:0]           route     [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] bad;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [2:0]           gnt_src   [NUM_PORTS];
  logic [2:0]           ptr       [NUM_PORTS];
  logic [NUM_PORTS-1:0] o_valid_q;
  logic [FLIT_W-1:0]    o_data_q  [NUM_PORTS];
  logic                 bad_pop;
  logic                 err;

  assign bus.i_ready = ~full;
  assign bus.o_valid = o_valid_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] dest_x;
    logic [ADDR_WIDTH-1:0] dest_y;
    logic [ADDR_WIDTH:0]   dx;
    logic [ADDR_WIDTH:0]   dy;
    logic                  bad_l;
    logic [2:0]            route_l;

    router_in_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.i_valid[p]),
      .push_data (bus.i_data[p*FLIT_W +: FLIT_W]),
      .pop       (pop[p]),
      .head      (head[p]),
      .empty     (empty[p]),
      .full      (full[p])
    );

    assign dest_x = head[p][DATA_WIDTH +: ADDR_WIDTH];
    assign dest_y = head[p][DATA_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];

    // Offsets are taken mod MESH_SIZE; 2*d <= MESH_SIZE selects the positive
    // direction, so the even-size tie also goes E/S.
    always_comb begin
      bad_l   = ({1'b0, dest_x} >= MESH_L) || ({1'b0, dest_y} >= MESH_L);
      dx      = {1'b0, dest_x} + MESH_L - X_L;
      if (dx >= MESH_L) dx = dx - MESH_L;
      dy      = {1'b0, dest_y} + MESH_L - Y_L;
      if (dy >= MESH_L) dy = dy - MESH_L;
      route_l = PORT_PE;
      if (!bad_l) begin
        if (dx != '0)
          route_l = ({dx, 1'b0} <= {1'b0, MESH_L}) ? PORT_E : PORT_W;
        else if (dy != '0)
          route_l = ({dy, 1'b0} <= {1'b0, MESH_L}) ? PORT_S : PORT_N;
      end
    end

    assign bad[p]   = bad_l;
    assign route[p] = route_l;
    assign bus.o_data[p*FLIT_W +: FLIT_W] = o_data_q[p];
  end

  // Each head requests a single output, so at most one grant pops a FIFO.
  always_comb begin
    logic [2:0] idx;
    idx     = '0;
    pop     = '0;
    bad_pop = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_valid[o] = 1'b0;
      gnt_src[o]   = '0;
      if (!o_valid_q[o] || bus.o_ready[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = rr_idx(ptr[o], 3'(k));
          if (!gnt_valid[o] && !empty[idx] && route[idx] == 3'(o)) begin
            gnt_valid[o] = 1'b1;
            gnt_src[o]   = idx;
          end
        end
      end
      if (gnt_valid[o]) begin
        pop[gnt_src[o]] = 1'b1;
        bad_pop         = bad_pop | bad[gnt_src[o]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= '0;
      err       <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        o_data_q[o] <= '0;
        ptr[o]      <= '0;
      end
    end else begin
      err <= err | bad_pop;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt_valid[o]) begin
          o_valid_q[o] <= 1'b1;
          o_data_q[o]  <= head[gnt_src[o]];
          ptr[o]       <= rr_idx(gnt_src[o], 3'd1);
        end else if (bus.o_ready[o]) begin
          o_valid_q[o] <= 1'b0;
        end
      end
    end
  end
endmodule
